// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller: CPU memory port to word RAM, output registers and synchronised inputs.
// Optional sticky unmapped-access reporting is enabled by defining MMIO_ERR_EN.
`timescale 1ns/1ps

module mmio_bus_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9,
   parameter int RAM_AW = 8,
   parameter int N_OUT = 2,
   parameter int N_IN = 2,
   parameter logic [ADDR_W-1:0] OUT_BASE = 9'h100,
   parameter logic [ADDR_W-1:0] IN_BASE = 9'h140
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              mem_cmd,
   input  logic [ADDR_W-1:0]       mem_addr,
   input  logic [DATA_W-1:0]       write_data,
   output logic [DATA_W-1:0]       read_data,
   output logic                    mem_ready,
   input  logic [N_IN*DATA_W-1:0]  in_port,
   output logic [N_OUT*DATA_W-1:0] out_port
`ifdef MMIO_ERR_EN
   ,
   output logic                    err_flag,
   output logic [ADDR_W-1:0]       err_addr
`endif
);

   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t state;
   state_t next_state;

   logic                    accept;
   logic                    access_en;
   logic                    req_write;
   logic [ADDR_W-1:0]       req_addr;
   logic [DATA_W-1:0]       req_data;

   logic                    hit_ram;
   logic                    hit_out;
   logic                    hit_in;
   logic                    unmapped;
   logic [N_OUT-1:0]        out_sel;
   logic [DATA_W-1:0]       out_rd_word;
   logic [DATA_W-1:0]       in_rd_word;
   logic [DATA_W-1:0]       ram_rd_word;
   logic [DATA_W-1:0]       rd_word;

   logic [DATA_W-1:0]       ram [2**RAM_AW];
   logic [DATA_W-1:0]       out_reg [N_OUT];
   logic [N_IN*DATA_W-1:0]  in_meta;
   logic [N_IN*DATA_W-1:0]  in_sync;

   assign accept = (mem_cmd == CMD_READ) || (mem_cmd == CMD_WRITE);

   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      mem_ready  = 1'b0;
      access_en  = 1'b0;
      case (state)
         IDLE: begin
            if (accept)
               next_state = ACCESS;
         end
         ACCESS: begin
            access_en  = 1'b1;
            next_state = RESP;
         end
         RESP: begin
            mem_ready  = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // The request is captured once in IDLE; the CPU's bus is not looked at again until the next IDLE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         req_write <= 1'b0;
         req_addr  <= '0;
         req_data  <= '0;
      end else if (state == IDLE && accept) begin
         req_write <= (mem_cmd == CMD_WRITE);
         req_addr  <= mem_addr;
         req_data  <= write_data;
      end
   end

   // Decode the latched address; RAM wins over OUT, OUT wins over IN.
   always_comb begin
      hit_ram     = (req_addr[ADDR_W-1] == 1'b0) && ((req_addr >> RAM_AW) == '0);
      out_sel     = '0;
      out_rd_word = '0;
      hit_in      = 1'b0;
      in_rd_word  = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (!hit_ram && req_addr == ADDR_W'(OUT_BASE + i)) begin
            out_sel[i]  = 1'b1;
            out_rd_word = out_reg[i];
         end
      end
      hit_out = |out_sel;
      for (int i = 0; i < N_IN; i++) begin
         if (!hit_ram && !hit_out && req_addr == ADDR_W'(IN_BASE + i)) begin
            hit_in     = 1'b1;
            in_rd_word = in_sync[i*DATA_W +: DATA_W];
         end
      end
      unmapped    = !hit_ram && !hit_out && !hit_in;
      ram_rd_word = ram[req_addr[RAM_AW-1:0]];
      if (hit_ram)
         rd_word = ram_rd_word;
      else if (hit_out)
         rd_word = out_rd_word;
      else if (hit_in)
         rd_word = in_rd_word;
      else
         rd_word = '0;
   end

   // RAM has no reset; the reset term still blocks a write from a transaction being aborted.
   always_ff @(posedge clk) begin
      if (reset && access_en && req_write && hit_ram)
         ram[req_addr[RAM_AW-1:0]] <= req_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         read_data <= '0;
         for (int i = 0; i < N_OUT; i++)
            out_reg[i] <= '0;
      end else if (access_en) begin
         if (req_write) begin
            for (int i = 0; i < N_OUT; i++)
               if (out_sel[i])
                  out_reg[i] <= req_data;
         end else begin
            read_data <= rd_word;
         end
      end
   end

   for (genvar g = 0; g < N_OUT; g++) begin : g_out_pack
      assign out_port[g*DATA_W +: DATA_W] = out_reg[g];
   end

   // Two-flop synchroniser on the raw inputs; reads only ever see the second stage.
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_meta <= '0;
         in_sync <= '0;
      end else begin
         in_meta <= in_port;
         in_sync <= in_meta;
      end
   end

`ifdef MMIO_ERR_EN
   // Only the first unmapped address is kept; the flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         err_flag <= 1'b0;
         err_addr <= '0;
      end else if (access_en && unmapped && !err_flag) begin
         err_flag <= 1'b1;
         err_addr <= req_addr;
      end
   end
`else
   logic unused_unmapped;
   assign unused_unmapped = unmapped;
`endif

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Self-checking bench for mmio_bus_ctrl: transaction-level model compared every cycle plus directed literal checks.
`timescale 1ns/1ps

module tb_mmio_bus_ctrl;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 9;
   localparam int RAM_AW   = 8;
   localparam int N_OUT    = 2;
   localparam int N_IN     = 2;
   localparam int OUT_BASE = 'h100;
   localparam int IN_BASE  = 'h140;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   logic                    clk;
   logic                    reset;
   logic [1:0]              mem_cmd;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       write_data;
   logic [DATA_W-1:0]       read_data;
   logic                    mem_ready;
   logic [N_IN*DATA_W-1:0]  in_port;
   logic [N_OUT*DATA_W-1:0] out_port;
`ifdef MMIO_ERR_EN
   logic                    err_flag;
   logic [ADDR_W-1:0]       err_addr;
`endif

   int checks = 0;
   int errors = 0;

   mmio_bus_ctrl #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .RAM_AW(RAM_AW),
      .N_OUT(N_OUT),
      .N_IN(N_IN),
      .OUT_BASE(ADDR_W'(OUT_BASE)),
      .IN_BASE(ADDR_W'(IN_BASE))
   ) dut (
      .clk(clk),
      .reset(reset),
      .mem_cmd(mem_cmd),
      .mem_addr(mem_addr),
      .write_data(write_data),
      .read_data(read_data),
      .mem_ready(mem_ready),
      .in_port(in_port),
      .out_port(out_port)
`ifdef MMIO_ERR_EN
      ,
      .err_flag(err_flag),
      .err_addr(err_addr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Transaction-level model: a request seen at an edge completes one edge later and is answered for one cycle.
   logic [DATA_W-1:0]       modelRam [2**RAM_AW];
   logic [DATA_W-1:0]       expOut [N_OUT];
   logic [DATA_W-1:0]       expRd;
   logic                    expReady;
   logic                    expErr;
   logic [ADDR_W-1:0]       expErrAddr;
   logic [N_IN*DATA_W-1:0]  inPrev1;
   logic [N_IN*DATA_W-1:0]  inPrev2;
   logic [N_IN*DATA_W-1:0]  inSeen;
   int                      edgeN = 0;
   int                      acceptEdge = 0;
   int                      doneEdge = 0;
   int                      a;
   bit                      pending = 0;
   bit                      modelValid = 0;
   logic                    pWrite;
   logic [ADDR_W-1:0]       pAddr;
   logic [DATA_W-1:0]       pData;

   always @(posedge clk) begin
      edgeN++;
      if (!reset) begin
         pending  = 0;
         doneEdge = edgeN - 2;
         expRd    = '0;
         expReady = 1'b0;
         expErr   = 1'b0;
         expErrAddr = '0;
         inPrev1  = '0;
         inPrev2  = '0;
         for (int i = 0; i < N_OUT; i++)
            expOut[i] = '0;
         modelValid = 1;
      end else begin
         inSeen   = inPrev2;
         inPrev2  = inPrev1;
         inPrev1  = in_port;
         expReady = 1'b0;
         if (pending && edgeN == acceptEdge + 1) begin
            pending  = 0;
            doneEdge = edgeN;
            expReady = 1'b1;
            a = int'(pAddr);
            if (a < 2**RAM_AW) begin
               if (pWrite) modelRam[a] = pData;
               else        expRd = modelRam[a];
            end else if (a >= OUT_BASE && a < OUT_BASE + N_OUT) begin
               if (pWrite) expOut[a - OUT_BASE] = pData;
               else        expRd = expOut[a - OUT_BASE];
            end else if (a >= IN_BASE && a < IN_BASE + N_IN) begin
               if (!pWrite) expRd = inSeen[(a - IN_BASE)*DATA_W +: DATA_W];
            end else begin
               if (!pWrite) expRd = '0;
               if (!expErr) begin
                  expErr     = 1'b1;
                  expErrAddr = pAddr;
               end
            end
         end else if (!pending && edgeN > doneEdge + 1 && (mem_cmd == MREAD || mem_cmd == MWRITE)) begin
            pending    = 1;
            acceptEdge = edgeN;
            pWrite     = (mem_cmd == MWRITE);
            pAddr      = mem_addr;
            pData      = write_data;
         end
      end
   end

   // Compare the DUT against the model on every falling edge once the model has seen a reset.
   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("mem_ready", 32'(mem_ready), 32'(expReady));
         checkOutput("read_data", 32'(read_data), 32'(expRd));
         for (int i = 0; i < N_OUT; i++)
            checkOutput("out_port", 32'(out_port[i*DATA_W +: DATA_W]), 32'(expOut[i]));
`ifdef MMIO_ERR_EN
         checkOutput("err_flag", 32'(err_flag), 32'(expErr));
         checkOutput("err_addr", 32'(err_addr), 32'(expErrAddr));
`endif
      end
   end

   task automatic applyStimulus(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data, input logic [N_IN*DATA_W-1:0] inVal);
      int waited;
      bit seen;
      @(negedge clk);
      mem_cmd    = cmd;
      mem_addr   = addr;
      write_data = data;
      in_port    = inVal;
      waited     = 0;
      seen       = 0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge clk);
         waited++;
         if (mem_ready === 1'b1)
            seen = 1;
      end
      checkOutput("latency", seen ? 32'(waited) : 32'd99, 32'd2);
      mem_cmd = MNONE;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, got %0d errors so far", errors);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset      = 1'b0;
      mem_cmd    = MNONE;
      mem_addr   = '0;
      write_data = '0;
      in_port    = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset read_data", 32'(read_data), 32'h0);
      checkOutput("reset mem_ready", 32'(mem_ready), 32'h0);
      checkOutput("reset out_port", out_port, 32'h0);
      reset = 1'b1;

      applyStimulus(MWRITE, 9'h005, 16'hBEEF, in_port);
      applyStimulus(MREAD, 9'h005, 16'h0000, in_port);
      checkOutput("ram rd 0x005", 32'(read_data), 32'hBEEF);

      applyStimulus(MWRITE, 9'h101, 16'h00A5, in_port);
      checkOutput("out1 after write", 32'(out_port[31:16]), 32'h00A5);
      checkOutput("out0 after write", 32'(out_port[15:0]), 32'h0000);
      checkOutput("read_data hold on write", 32'(read_data), 32'hBEEF);
      applyStimulus(MREAD, 9'h101, 16'h0000, in_port);
      checkOutput("out1 readback", 32'(read_data), 32'h00A5);

      applyStimulus(MWRITE, 9'h0FF, 16'h1357, in_port);
      applyStimulus(MREAD, 9'h0FF, 16'h0000, in_port);
      checkOutput("ram top word", 32'(read_data), 32'h1357);

      @(negedge clk);
      in_port[31:16] = 16'h1234;
      repeat (3) @(negedge clk);
      applyStimulus(MREAD, 9'h141, 16'h0000, in_port);
      checkOutput("in1 read", 32'(read_data), 32'h1234);

      applyStimulus(MREAD, 9'h140, 16'h0000, {16'h1234, 16'h5A5A});
      checkOutput("in0 sync delay", 32'(read_data), 32'h0000);
      applyStimulus(MREAD, 9'h140, 16'h0000, in_port);
      checkOutput("in0 after sync", 32'(read_data), 32'h5A5A);

      @(negedge clk);
      mem_cmd  = 2'b11;
      mem_addr = 9'h005;
      repeat (4) begin
         @(negedge clk);
         checkOutput("cmd 11 idle", 32'(mem_ready), 32'h0);
      end
      mem_cmd = MNONE;

      applyStimulus(MREAD, 9'h1F0, 16'h0000, in_port);
      checkOutput("unmapped read", 32'(read_data), 32'h0000);
`ifdef MMIO_ERR_EN
      checkOutput("err_flag set", 32'(err_flag), 32'h1);
      checkOutput("err_addr first", 32'(err_addr), 32'h1F0);
`endif
      applyStimulus(MREAD, 9'h1F1, 16'h0000, in_port);
      applyStimulus(MWRITE, 9'h102, 16'hDEAD, in_port);
      checkOutput("unmapped write out", out_port, 32'h00A5_0000);
      applyStimulus(MREAD, 9'h142, 16'h0000, in_port);
      checkOutput("unmapped in idx", 32'(read_data), 32'h0000);
`ifdef MMIO_ERR_EN
      checkOutput("err_addr kept", 32'(err_addr), 32'h1F0);
`endif

      applyStimulus(MREAD, 9'h005, 16'h0000, in_port);
      @(negedge clk);
      mem_cmd    = MWRITE;
      mem_addr   = 9'h100;
      write_data = 16'hFFFF;
      @(negedge clk);
      reset   = 1'b0;
      mem_cmd = MNONE;
      @(negedge clk);
      reset = 1'b1;
      checkOutput("abort out0", 32'(out_port[15:0]), 32'h0000);
      checkOutput("abort mem_ready", 32'(mem_ready), 32'h0);
      checkOutput("abort read_data", 32'(read_data), 32'h0000);
      @(negedge clk);
      checkOutput("abort idle", 32'(mem_ready), 32'h0);
`ifdef MMIO_ERR_EN
      checkOutput("err cleared", 32'(err_flag), 32'h0);
`endif

      applyStimulus(MREAD, 9'h100, 16'h0000, in_port);
      checkOutput("out0 after abort", 32'(read_data), 32'h0000);
      applyStimulus(MREAD, 9'h101, 16'h0000, in_port);
      checkOutput("out1 after reset", 32'(read_data), 32'h0000);
      applyStimulus(MREAD, 9'h005, 16'h0000, in_port);
      checkOutput("ram survives reset", 32'(read_data), 32'hBEEF);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
